// File: rtl/dir_button_debouncer_pkg.sv
// dir_button_debouncer_pkg: shared debounce FSM state type and button index constants.
package dir_button_debouncer_pkg;
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } db_state_t;
  localparam int NUM_BTN    = 5;
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_CENTER = 4;
endpackage

// File: rtl/dir_button_debouncer_cell.sv
// btn_debounce_cell: one-button 2-flop synchroniser plus debounce FSM with press pulse.
// Auto-repeat pulses while held are added when DIR_BTN_REPEAT_EN is defined.
module btn_debounce_cell
  import dir_button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
`ifdef DIR_BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic r_s1, r_s2, r_level, r_pulse;
  db_state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic w_done, w_press, w_rep;
  assign w_done = r_cnt == LAST;
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_press   = 1'b0;
    case (r_state)
      IDLE: if (r_s2) begin
        w_next    = CHK_PRESS;
        w_cnt_nxt = '0;
      end
      CHK_PRESS: if (!r_s2) w_next = IDLE;
      else begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_next    = w_done ? PRESSED : CHK_PRESS;
        w_press   = w_done;
      end
      PRESSED: if (!r_s2) begin
        w_next    = CHK_RELEASE;
        w_cnt_nxt = '0;
      end
      CHK_RELEASE: if (r_s2) w_next = PRESSED;
      else begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_next    = w_done ? IDLE : CHK_RELEASE;
      end
    endcase
  end
`ifdef DIR_BTN_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] r_rcnt;
  logic r_rphase;
  // Only a cell that stays in PRESSED repeats; the repeat count freezes in CHK_RELEASE.
  assign w_rep = r_state == PRESSED && r_s2 &&
                 r_rcnt == (r_rphase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  always_ff @(posedge clk) begin
    if (rst || r_state == IDLE || r_state == CHK_PRESS) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b0;
    end else if (w_rep) begin
      r_rcnt   <= '0;
      r_rphase <= 1'b1;
    end else if (r_state == PRESSED && r_s2) r_rcnt <= r_rcnt + 1'b1;
  end
`else
  assign w_rep = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_next == PRESSED || w_next == CHK_RELEASE;
      r_pulse <= w_press | w_rep;
    end
  end
  assign o_level = r_level;
  assign o_pulse = r_pulse;
endmodule

// File: rtl/dir_button_debouncer.sv
// dir_button_debouncer: five independent debounce cells plus any_pressed OR.
// Define DIR_BTN_REPEAT_EN to enable auto-repeat press pulses while a button is held.
module dir_button_debouncer
  import dir_button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_pressed
);
  if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("dir_button_debouncer: illegal parameter set");
  end
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef DIR_BTN_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (btn_raw[i]),
      .o_level(btn_level[i]),
      .o_pulse(btn_pulse[i])
    );
  end
  assign any_pressed = |btn_level;
endmodule

// File: tb/tb_dir_button_debouncer.sv
// tb_dir_button_debouncer: directed stimulus with a pulse scoreboard and decoupled monitor.
module tb_dir_button_debouncer;
  typedef struct {
    int         cyc;
    logic [4:0] pulse;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level, btn_pulse;
  logic any_pressed;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  exp_t sb[$];
  dir_button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (24),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .any_pressed(any_pressed)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      fails++;
      $display("FAIL pulse_missing cycle %0d: got none, required %b", e.cyc, e.pulse);
    end
    if (btn_pulse !== 5'b0) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected cycle %0d: got %b, required none", cyc, btn_pulse);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.pulse !== btn_pulse) begin
          fails++;
          $display("FAIL pulse cycle %0d value %b: required cycle %0d value %b", cyc, btn_pulse, e.cyc, e.pulse);
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b, required %b", name, cyc, got, exp);
    end
  endtask
  initial begin
    int n;
    step(3);
    chk("reset_level", btn_level, 5'b0);
    chk("reset_pulse", btn_pulse, 5'b0);
    chk("reset_any", {4'b0, any_pressed}, 5'b0);
    rst = 1'b0;
    step(2);
    n = cyc;
    btn_raw = 5'b00010;
    sb.push_back('{n + 7, 5'b00010});
    step(6);
    chk("press_level_early", btn_level, 5'b0);
    step(1);
    chk("press_level", btn_level, 5'b00010);
    chk("press_any", {4'b0, any_pressed}, 5'b1);
    step(3);
    btn_raw[1] = 1'b0;
    step(1);
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_hold_level", btn_level, 5'b00010);
    end
    btn_raw = 5'b0;
    step(6);
    chk("release_level_early", btn_level, 5'b00010);
    step(1);
    chk("release_level", btn_level, 5'b0);
    chk("release_any", {4'b0, any_pressed}, 5'b0);
    btn_raw = 5'b00100;
    step(3);
    btn_raw = 5'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("short_glitch_level", btn_level, 5'b0);
    end
    n = cyc;
    btn_raw = 5'b01001;
    sb.push_back('{n + 7, 5'b01001});
    step(7);
    chk("dual_level", btn_level, 5'b01001);
    step(2);
    btn_raw = 5'b01000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("dual_any", {4'b0, any_pressed}, 5'b1);
    end
    chk("dual_partial_level", btn_level, 5'b01000);
    btn_raw = 5'b0;
    step(6);
    chk("dual_any_late", {4'b0, any_pressed}, 5'b1);
    step(1);
    chk("dual_any_clear", {4'b0, any_pressed}, 5'b0);
    n = cyc;
    btn_raw = 5'b10000;
    sb.push_back('{n + 7, 5'b10000});
    step(9);
    chk("center_level", btn_level, 5'b10000);
    rst = 1'b1;
    step(1);
    chk("midrst_level", btn_level, 5'b0);
    chk("midrst_pulse", btn_pulse, 5'b0);
    chk("midrst_any", {4'b0, any_pressed}, 5'b0);
    rst = 1'b0;
    n = cyc;
    sb.push_back('{n + 7, 5'b10000});
    step(6);
    chk("rearm_level_early", btn_level, 5'b0);
    step(1);
    chk("rearm_level", btn_level, 5'b10000);
    btn_raw = 5'b0;
    step(8);
    chk("rearm_release", btn_level, 5'b0);
    n = cyc;
    btn_raw = 5'b00010;
    sb.push_back('{n + 7, 5'b00010});
`ifdef DIR_BTN_REPEAT_EN
    for (int k = 17; k <= 42; k += 5) sb.push_back('{n + k, 5'b00010});
`endif
    step(40);
    chk("long_hold_level", btn_level, 5'b00010);
    btn_raw = 5'b0;
    step(12);
    chk("long_release_level", btn_level, 5'b0);
    step(3);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
